jtag_tap_sampled: RTL and testbench
===================================

# jtag_tap_sampled

Oversampled IEEE 1149.1 TAP controller that consumes the JTAG pin bundle from the simulation JTAG driver and returns TDO/TDO-driven to it. It runs on the system clock only: TCK is treated as slow data, synchronized, and edge-detected. It provides IDCODE, BYPASS and one user data register with a parallel capture/update port toward the debug module interface.

## Interface
- IR_LEN, 5: instruction register width.
- IDCODE_VALUE, 32'h1000_0DB3: value captured in IDCODE; bit 0 must be 1.
- USER_IR, 5'h11: IR code selecting the user register.
- USER_DR_LEN, 41: user register width, minimum 2.

- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- jtag_TCK  in  1  JTAG clock, asynchronous level.
- jtag_TMS  in  1  mode select.
- jtag_TDI  in  1  serial data in.
- jtag_TRSTn  in  1  active-low TAP reset, asynchronous level.
- jtag_TDO_data  out  1  serial data out.
- jtag_TDO_driven  out  1  high while TDO is valid (Shift-IR/Shift-DR).
- dr_capture_data  in  USER_DR_LEN  parallel value loaded in Capture-DR when USER is selected.
- dr_update_data  out  USER_DR_LEN  last shifted user value.
- dr_update_valid  out  1  one-cycle pulse on user Update-DR.
- tap_state  out  4  current TAP state (debug).

## Operation
- Synchronizers: TCK, TMS, TDI and TRSTn each pass through 2 flops (s1, s2). TCK also has a third flop (s3). tck_rise = s2 & ~s3; tck_fall = ~s2 & s3. TMS/TDI are used from their s2 stage.
- State encoding:
  - 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR
  - 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR
- Transitions: standard 1149.1, evaluated only on tck_rise using synchronized TMS.
- Actions on tck_rise, based on the state before the transition:
  - CapIR: IR shift register loads {IR_LEN-2 zeros, 2'b01}.
  - ShIR: shift right, synchronized TDI into the MSB.
  - UpdIR: IR loads the shift register.
  - CapDR: selected DR loads IDCODE_VALUE (IDCODE), 0 (BYPASS, 1 bit), or dr_capture_data (USER).
  - ShDR: selected DR shifts right, TDI into the MSB.
  - UpdDR with USER: dr_update_data loads the shift register and dr_update_valid pulses.
- IR decode: 5'h01 selects IDCODE; USER_IR selects USER; all other codes (including all-ones) select BYPASS.
- Entering TLR by any path: IR = 5'h01 (IDCODE).
- TDO, updated on tck_fall only:
  - In ShIR/ShDR: jtag_TDO_driven = 1 and jtag_TDO_data = LSB of the active shift register.
  - In all other states: both outputs 0.
- Synchronized TRSTn low: state forced to TLR and IR to IDCODE every cycle. This overrides a simultaneous tck_rise/tck_fall. TDO outputs go to 0. dr_update_data is kept.

## Timing
- Reset values: tap_state = 0 (TLR), IR = 5'h01, jtag_TDO_data = 0, jtag_TDO_driven = 0, dr_update_data = 0, dr_update_valid = 0, all synchronizer flops = 0.
- Latency: a TCK edge first sampled at clock edge N produces the state/register update at edge N+2. dr_update_valid is high for exactly the cycle after that update edge.
- TDO changes at edge N+2 following the first sampling of a TCK falling edge.
- Operating constraint: TCK high and low phases are each ≥4 clock periods. TMS/TDI must be stable ≥3 clock periods before the TCK rising edge. Outside this constraint behaviour is undefined.
- Five consecutive tck_rise with TMS=1 reach TLR from any state.
- reset asserted mid-shift: all state returns to reset values immediately. Partial shift contents are discarded and no update pulse is produced.
- A TCK glitch shorter than 1 clock period may be missed. It must never produce two edges.

## Test plan
- Reset, then TMS=1 ×5, then TMS=0 (RTI) → tap_state = 1, TDO_driven = 0, IR = 5'h01.
- Go to ShDR from RTI and shift 32 bits → TDO bits LSB-first equal 32'h1000_0DB3; TDO_driven high only during ShDR.
- Load IR 5'h1F (BYPASS), shift 8'hA5 then one extra bit → TDO sequence is 0 followed by the A5 bits delayed by one.
- Load IR 5'h11 with dr_capture_data = 41'h1_2345_6789A, then shift 41'h0AB_CDEF_0123 → TDO returns 41'h1_2345_6789A; at UpdDR, dr_update_data = 41'h0AB_CDEF_0123 with a one-cycle valid pulse.
- Drop TRSTn for 3 clocks during user ShDR → tap_state = 0, IR = 5'h01, no dr_update_valid, dr_update_data unchanged.
- Assert reset during ShIR after 3 bits → all outputs at reset values; a following IDCODE scan still returns 32'h1000_0DB3.

Source files
------------

// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP controller oversampled on the system clock; TCK is synchronized and
// edge-detected as data. Provides IDCODE, BYPASS and one user DR with parallel capture/update.
module jtag_tap_sampled #(
    parameter int                IR_LEN       = 5,
    parameter logic [31:0]       IDCODE_VALUE = 32'h1000_0DB3,
    parameter logic [IR_LEN-1:0] USER_IR      = 5'h11,
    parameter int                USER_DR_LEN  = 41
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   jtag_TCK,
    input  logic                   jtag_TMS,
    input  logic                   jtag_TDI,
    input  logic                   jtag_TRSTn,
    output logic                   jtag_TDO_data,
    output logic                   jtag_TDO_driven,
    input  logic [USER_DR_LEN-1:0] dr_capture_data,
    output logic [USER_DR_LEN-1:0] dr_update_data,
    output logic                   dr_update_valid,
    output logic [3:0]             tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI     = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR  = 4'd5,  PS_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR  = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PS_IR   = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } state_e;

    localparam logic [IR_LEN-1:0] IR_IDCODE  = {{(IR_LEN-1){1'b0}}, 1'b1};
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-2){1'b0}}, 2'b01};

    state_e state_q, state_d;
    logic tck_s1_q, tck_s2_q, tck_s3_q;
    logic tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q, trst_s1_q, trst_s2_q;
    logic [IR_LEN-1:0]      ir_q, ir_sr_q;
    logic [31:0]            id_sr_q;
    logic                   byp_q;
    logic [USER_DR_LEN-1:0] usr_sr_q, upd_q;
    logic                   upd_vld_q, tdo_q, drv_q;
    logic                   tck_rise, tck_fall, sel_id, sel_usr;

    // TCK gets a third stage so a single transition yields exactly one rise or fall strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {tck_s1_q, tck_s2_q, tck_s3_q} <= 3'b000;
            {tms_s1_q, tms_s2_q, tdi_s1_q, tdi_s2_q} <= 4'b0000;
            {trst_s1_q, trst_s2_q} <= 2'b00;
        end else begin
            {tck_s1_q, tck_s2_q, tck_s3_q} <= {jtag_TCK, tck_s1_q, tck_s2_q};
            {tms_s1_q, tms_s2_q} <= {jtag_TMS, tms_s1_q};
            {tdi_s1_q, tdi_s2_q} <= {jtag_TDI, tdi_s1_q};
            {trst_s1_q, trst_s2_q} <= {jtag_TRSTn, trst_s1_q};
        end
    end

    assign tck_rise = tck_s2_q & ~tck_s3_q;
    assign tck_fall = ~tck_s2_q & tck_s3_q;
    assign sel_id   = (ir_q == IR_IDCODE);
    assign sel_usr  = (ir_q == USER_IR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            case (state_q)
                TLR:     state_d = tms_s2_q ? TLR    : RTI;
                RTI:     state_d = tms_s2_q ? SEL_DR : RTI;
                SEL_DR:  state_d = tms_s2_q ? SEL_IR : CAP_DR;
                CAP_DR:  state_d = tms_s2_q ? EX1_DR : SH_DR;
                SH_DR:   state_d = tms_s2_q ? EX1_DR : SH_DR;
                EX1_DR:  state_d = tms_s2_q ? UPD_DR : PS_DR;
                PS_DR:   state_d = tms_s2_q ? EX2_DR : PS_DR;
                EX2_DR:  state_d = tms_s2_q ? UPD_DR : SH_DR;
                UPD_DR:  state_d = tms_s2_q ? SEL_DR : RTI;
                SEL_IR:  state_d = tms_s2_q ? TLR    : CAP_IR;
                CAP_IR:  state_d = tms_s2_q ? EX1_IR : SH_IR;
                SH_IR:   state_d = tms_s2_q ? EX1_IR : SH_IR;
                EX1_IR:  state_d = tms_s2_q ? UPD_IR : PS_IR;
                PS_IR:   state_d = tms_s2_q ? EX2_IR : PS_IR;
                EX2_IR:  state_d = tms_s2_q ? UPD_IR : SH_IR;
                UPD_IR:  state_d = tms_s2_q ? SEL_DR : RTI;
                default: state_d = TLR;
            endcase
        end
        if (!trst_s2_q) state_d = TLR;
    end

    // Register actions key off the state before the transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q      <= IR_IDCODE;
            ir_sr_q   <= '0;
            id_sr_q   <= '0;
            byp_q     <= 1'b0;
            usr_sr_q  <= '0;
            upd_q     <= '0;
            upd_vld_q <= 1'b0;
            tdo_q     <= 1'b0;
            drv_q     <= 1'b0;
        end else begin
            upd_vld_q <= 1'b0;
            if (!trst_s2_q) begin
                ir_q  <= IR_IDCODE;
                tdo_q <= 1'b0;
                drv_q <= 1'b0;
            end else begin
                if (tck_rise) begin
                    case (state_q)
                        CAP_IR: ir_sr_q <= IR_CAPTURE;
                        SH_IR:  ir_sr_q <= {tdi_s2_q, ir_sr_q[IR_LEN-1:1]};
                        UPD_IR: ir_q    <= ir_sr_q;
                        CAP_DR: begin
                            if (sel_usr)     usr_sr_q <= dr_capture_data;
                            else if (sel_id) id_sr_q  <= IDCODE_VALUE;
                            else             byp_q    <= 1'b0;
                        end
                        SH_DR: begin
                            if (sel_usr)     usr_sr_q <= {tdi_s2_q, usr_sr_q[USER_DR_LEN-1:1]};
                            else if (sel_id) id_sr_q  <= {tdi_s2_q, id_sr_q[31:1]};
                            else             byp_q    <= tdi_s2_q;
                        end
                        UPD_DR: begin
                            if (sel_usr) begin
                                upd_q     <= usr_sr_q;
                                upd_vld_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    if (state_d == TLR) ir_q <= IR_IDCODE;
                end
                if (tck_fall) begin
                    drv_q <= (state_q == SH_IR) || (state_q == SH_DR);
                    if (state_q == SH_IR)      tdo_q <= ir_sr_q[0];
                    else if (state_q == SH_DR) tdo_q <= sel_usr ? usr_sr_q[0] : (sel_id ? id_sr_q[0] : byp_q);
                    else                       tdo_q <= 1'b0;
                end
            end
        end
    end

    assign jtag_TDO_data   = tdo_q;
    assign jtag_TDO_driven = drv_q;
    assign dr_update_data  = upd_q;
    assign dr_update_valid = upd_vld_q;
    assign tap_state       = state_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: a state-walk vector table plus hand-written scan sequences.
module tb_jtag_tap_sampled;

    localparam int UL = 41;
    localparam logic [31:0] IDC = 32'h1000_0DB3;

    logic          clock = 1'b0, reset = 1'b1;
    logic          jtag_TCK = 1'b0, jtag_TMS = 1'b1, jtag_TDI = 1'b0, jtag_TRSTn = 1'b1;
    logic          jtag_TDO_data, jtag_TDO_driven, dr_update_valid;
    logic [UL-1:0] dr_capture_data = '0, dr_update_data;
    logic [3:0]    tap_state;

    int nvec = 0, nmis = 0, vcnt = 0;

    jtag_tap_sampled dut (
        .clock(clock), .reset(reset), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
        .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO_data(jtag_TDO_data),
        .jtag_TDO_driven(jtag_TDO_driven), .dr_capture_data(dr_capture_data),
        .dr_update_data(dr_update_data), .dr_update_valid(dr_update_valid), .tap_state(tap_state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) if (dr_update_valid) vcnt++;

    typedef struct { logic tms; logic [3:0] st; logic drv; } walk_t;
    walk_t walk [22];

    task automatic clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One TCK period; TDO/driven sampled just before the rising edge, as a real probe does.
    task automatic tck(input logic tms, input logic tdi, output logic tdo, output logic drv);
        jtag_TMS = tms; jtag_TDI = tdi;
        clks(4);
        tdo = jtag_TDO_data; drv = jtag_TDO_driven;
        jtag_TCK = 1'b1; clks(5);
        jtag_TCK = 1'b0; clks(5);
    endtask

    task automatic step(input logic tms);
        logic t, d;
        tck(tms, 1'b0, t, d);
    endtask

    task automatic shift(input logic [63:0] din, input int n, output logic [63:0] dout, output int dcnt);
        logic t, d;
        dout = '0; dcnt = 0;
        for (int i = 0; i < n; i++) begin
            tck(i == n - 1, din[i], t, d);
            dout[i] = t;
            if (d) dcnt++;
        end
    endtask

    // From RTI: full DR scan back to RTI; pdrv is driven as seen in Exit1-DR.
    task automatic dr_scan(input logic [63:0] din, input int n, output logic [63:0] dout,
                           output int dcnt, output logic pdrv);
        logic t;
        step(1); step(0); step(0);
        shift(din, n, dout, dcnt);
        tck(1'b1, 1'b0, t, pdrv);
        step(0);
    endtask

    task automatic ir_scan(input logic [4:0] ir, output logic [63:0] dout);
        int dc;
        step(1); step(1); step(0); step(0);
        shift({59'd0, ir}, 5, dout, dc);
        step(1); step(0);
    endtask

    initial begin
        logic [63:0] dout;
        int          dc;
        logic        pd;

        walk = '{'{0,1,0}, '{1,2,0}, '{0,3,0}, '{0,4,1}, '{1,5,0}, '{0,6,0}, '{1,7,0},
                 '{0,4,1}, '{1,5,0}, '{1,8,0}, '{1,2,0}, '{1,9,0}, '{0,10,0}, '{1,12,0},
                 '{0,13,0}, '{1,14,0}, '{0,11,1}, '{1,12,0}, '{1,15,0}, '{1,2,0},
                 '{1,9,0}, '{1,0,0}};

        clks(3);
        chk("rst_state", {60'd0, tap_state}, 64'd0);
        chk("rst_tdo", {62'd0, jtag_TDO_data, jtag_TDO_driven}, 64'd0);
        chk("rst_upd", {dr_update_valid, dr_update_data}, 64'd0);
        reset = 1'b0; clks(3);

        for (int i = 0; i < 5; i++) step(1);
        chk("tlr_after_5", {60'd0, tap_state}, 64'd0);

        foreach (walk[i]) begin
            step(walk[i].tms);
            chk($sformatf("walk%0d_state", i), {60'd0, tap_state}, {60'd0, walk[i].st});
            chk($sformatf("walk%0d_drv", i), {63'd0, jtag_TDO_driven}, {63'd0, walk[i].drv});
        end

        // TCK rise sampled at edge N must move the state at N+2, not earlier.
        jtag_TMS = 1'b0; clks(4);
        jtag_TCK = 1'b1; clks(2);
        chk("lat_before", {60'd0, tap_state}, 64'd0);
        clks(1);
        chk("lat_at", {60'd0, tap_state}, 64'd1);
        clks(4); jtag_TCK = 1'b0; clks(5);

        dr_scan(64'd0, 32, dout, dc, pd);
        chk("idcode", dout, {32'd0, IDC});
        chk("idcode_drv", {32'd0, dc}, 64'd32);
        chk("idcode_pdrv", {63'd0, pd}, 64'd0);

        ir_scan(5'h1F, dout);
        chk("ir_capture", dout, 64'h01);
        dr_scan({55'd0, 1'b0, 8'hA5}, 9, dout, dc, pd);
        chk("bypass", dout, 64'h14A);

        ir_scan(5'h11, dout);
        dr_capture_data = 41'h1_2345_6789A;
        dr_scan({23'd0, 41'h0AB_CDEF_0123}, UL, dout, dc, pd);
        chk("user_tdo", dout, {23'd0, 41'h1_2345_6789A});
        chk("user_upd", {23'd0, dr_update_data}, {23'd0, 41'h0AB_CDEF_0123});
        chk("user_vld_cycles", {32'd0, vcnt}, 64'd1);
        chk("user_vld_low", {63'd0, dr_update_valid}, 64'd0);

        step(1); step(0); step(0);
        for (int i = 0; i < 5; i++) step(1'b0);
        chk("trst_pre_drv", {63'd0, jtag_TDO_driven}, 64'd1);
        jtag_TRSTn = 1'b0; clks(3);
        jtag_TRSTn = 1'b1; clks(3);
        chk("trst_state", {60'd0, tap_state}, 64'd0);
        chk("trst_tdo", {62'd0, jtag_TDO_data, jtag_TDO_driven}, 64'd0);
        chk("trst_upd", {23'd0, dr_update_data}, {23'd0, 41'h0AB_CDEF_0123});
        chk("trst_vld", {32'd0, vcnt}, 64'd1);
        step(0);
        dr_scan(64'd0, 32, dout, dc, pd);
        chk("trst_idcode", dout, {32'd0, IDC});

        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 3; i++) step(1'b0);
        chk("shir_state", {60'd0, tap_state}, 64'd11);
        reset = 1'b1; clks(1);
        chk("arst_state", {60'd0, tap_state}, 64'd0);
        chk("arst_tdo", {62'd0, jtag_TDO_data, jtag_TDO_driven}, 64'd0);
        chk("arst_upd", {dr_update_valid, dr_update_data}, 64'd0);
        reset = 1'b0; clks(3);
        step(0);
        dr_scan(64'd0, 32, dout, dc, pd);
        chk("arst_idcode", dout, {32'd0, IDC});
        chk("final_vld", {32'd0, vcnt}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
